// File: rtl/lfsr_pkg.sv
// ----------------------------------------------------------------------------
// lfsr_pkg
// Shared types, default tap masks and the LFSR step function used by the
// parametrised random source (lfsr_core + lfsr_random_gen_param).
// No ports: package only.
// ----------------------------------------------------------------------------
package lfsr_pkg;

    // Draw engine states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DRAW = 1'b1
    } draw_state_t;

    // Maximal-length tap masks for common widths
    localparam logic [3:0]  TAPS_W4  = 4'hC;
    localparam logic [5:0]  TAPS_W6  = 6'h30;
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;

    // One Fibonacci step: shift left, feedback = XOR of tapped bits into bit 0.
    // Works on a 32-bit container; bits at and above 'width' are cleared so the
    // caller can truncate freely.
    function automatic logic [31:0] step(
        input logic [31:0] state,
        input logic [31:0] taps,
        input int          width
    );
        logic [31:0] mask;
        mask = (32'h1 << width) - 32'h1;
        return ((state << 1) | {31'b0, ^(state & taps & mask)}) & mask;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// ----------------------------------------------------------------------------
// lfsr_core
// Holds the LFSR state. Handles runtime seed load (with zero substitution),
// the all-zero lockup guard, and advancing on either a draw-engine step or a
// free-run enable while the draw engine is idle.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          synchronous active-low reset
//   i_en           free-run advance request (ignored while i_busy)
//   i_busy         draw engine is in DRAW
//   i_draw_step    draw engine consumes a step this edge
//   i_load         load i_load_val this edge (highest priority after reset)
//   i_load_val     runtime seed
//   o_state        raw LFSR state
//   o_cand         low OUT_WIDTH bits of the state that would follow o_state
//   o_zero         state is all-zero; this edge is the guard reload
//   o_seed_fixed   one-cycle pulse when SEED replaced a zero state/seed
// ----------------------------------------------------------------------------
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
    parameter logic [WIDTH-1:0] SEED      = 8'h01,
    parameter int               OUT_WIDTH = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_busy,
    input  logic                 i_draw_step,
    input  logic                 i_load,
    input  logic [WIDTH-1:0]     i_load_val,
    output logic [WIDTH-1:0]     o_state,
    output logic [OUT_WIDTH-1:0] o_cand,
    output logic                 o_zero,
    output logic                 o_seed_fixed
);

    logic [WIDTH-1:0] r_state;
    logic             r_seed_fixed;
    logic [WIDTH-1:0] w_next;
    logic             w_advance;
    logic             w_zero;

    assign w_next    = WIDTH'(step(32'(r_state), 32'(TAPS), WIDTH));
    assign w_zero    = (r_state == '0);
    assign w_advance = i_draw_step | (i_en & ~i_busy);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= SEED;
            r_seed_fixed <= 1'b0;
        end else if (i_load) begin
            if (i_load_val == '0) begin
                r_state      <= SEED;
                r_seed_fixed <= 1'b1;
            end else begin
                r_state      <= i_load_val;
                r_seed_fixed <= 1'b0;
            end
        end else if (w_zero) begin
            // A zero state would stick forever; recover to SEED.
            r_state      <= SEED;
            r_seed_fixed <= 1'b1;
        end else begin
            if (w_advance) begin
                r_state <= w_next;
            end
            r_seed_fixed <= 1'b0;
        end
    end

    assign o_state      = r_state;
    assign o_cand       = w_next[OUT_WIDTH-1:0];
    assign o_zero       = w_zero;
    assign o_seed_fixed = r_seed_fixed;

endmodule

// File: rtl/lfsr_random_gen_param.sv
// ----------------------------------------------------------------------------
// lfsr_random_gen_param
// Parametrised pseudo-random source. A req in IDLE draws a value bounded to
// [0, RANGE-1] by rejection sampling; after MAX_TRIES rejected candidates the
// last candidate is folded down by RANGE and accepted.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          synchronous active-low reset
//   i_en           free-run LFSR advance while idle
//   i_seed_load    load i_seed_in this edge (aborts a draw)
//   i_seed_in      runtime seed
//   i_req          draw request, sampled only in IDLE
//   o_valid        one-cycle pulse: o_value holds a new draw
//   o_value        last accepted draw, held until next o_valid
//   o_busy         draw engine in DRAW
//   o_state_out    raw LFSR state
//   o_seed_fixed   one-cycle pulse: a zero seed/state was replaced by SEED
// ----------------------------------------------------------------------------
module lfsr_random_gen_param
    import lfsr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
    parameter logic [WIDTH-1:0] SEED      = 8'h01,
    parameter int               OUT_WIDTH = 6,
    parameter int               RANGE     = 40,
    parameter int               MAX_TRIES = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_seed_load,
    input  logic [WIDTH-1:0]     i_seed_in,
    input  logic                 i_req,
    output logic                 o_valid,
    output logic [OUT_WIDTH-1:0] o_value,
    output logic                 o_busy,
    output logic [WIDTH-1:0]     o_state_out,
    output logic                 o_seed_fixed
);

    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam logic [OUT_WIDTH:0] RANGE_X  = (OUT_WIDTH + 1)'(RANGE);
    localparam logic [TW-1:0]      LAST_TRY = TW'(MAX_TRIES - 1);

    draw_state_t            r_state;
    draw_state_t            w_state_nxt;
    logic [TW-1:0]          r_tries;
    logic [TW-1:0]          w_tries_nxt;
    logic                   r_valid;
    logic                   w_valid_nxt;
    logic [OUT_WIDTH-1:0]   r_value;
    logic [OUT_WIDTH-1:0]   w_value_nxt;
    logic                   w_draw_step;
    logic                   w_busy;

    logic [OUT_WIDTH-1:0]   w_cand;
    logic                   w_zero;
    logic                   w_in_range;
    logic [OUT_WIDTH-1:0]   w_folded;

    lfsr_core #(
        .WIDTH     (WIDTH),
        .TAPS      (TAPS),
        .SEED      (SEED),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_core (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_en         (i_en),
        .i_busy       (w_busy),
        .i_draw_step  (w_draw_step),
        .i_load       (i_seed_load),
        .i_load_val   (i_seed_in),
        .o_state      (o_state_out),
        .o_cand       (w_cand),
        .o_zero       (w_zero),
        .o_seed_fixed (o_seed_fixed)
    );

    assign w_in_range = ({1'b0, w_cand} < RANGE_X);
    // Modulo 2^OUT_WIDTH this equals the wider subtraction truncated; since
    // RANGE > 2^(OUT_WIDTH-1) a rejected candidate minus RANGE is in range.
    assign w_folded   = w_cand - RANGE_X[OUT_WIDTH-1:0];

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
            r_tries <= '0;
            r_valid <= 1'b0;
            r_value <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tries <= w_tries_nxt;
            r_valid <= w_valid_nxt;
            r_value <= w_value_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_tries_nxt = r_tries;
        w_valid_nxt = 1'b0;
        w_value_nxt = r_value;
        w_draw_step = 1'b0;
        if (i_seed_load) begin
            w_state_nxt = ST_IDLE;
            w_tries_nxt = '0;
        end else if (!w_zero) begin
            // While the core recovers from a zero state no step happens,
            // so the draw engine simply waits one edge.
            case (r_state)
                ST_IDLE: begin
                    if (i_req) begin
                        w_draw_step = 1'b1;
                        if (w_in_range) begin
                            w_value_nxt = w_cand;
                            w_valid_nxt = 1'b1;
                        end else if (MAX_TRIES == 1) begin
                            w_value_nxt = w_folded;
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_tries_nxt = TW'(1);
                            w_state_nxt = ST_DRAW;
                        end
                    end
                end
                ST_DRAW: begin
                    w_draw_step = 1'b1;
                    if (w_in_range) begin
                        w_value_nxt = w_cand;
                        w_valid_nxt = 1'b1;
                        w_tries_nxt = '0;
                        w_state_nxt = ST_IDLE;
                    end else if (r_tries == LAST_TRY) begin
                        w_value_nxt = w_folded;
                        w_valid_nxt = 1'b1;
                        w_tries_nxt = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_tries_nxt = r_tries + TW'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_tries_nxt = '0;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        w_busy  = (r_state == ST_DRAW);
        o_busy  = w_busy;
        o_valid = r_valid;
        o_value = r_value;
    end

endmodule

// File: tb/tb_lfsr_random_gen_param.sv
module tb_lfsr_random_gen_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       seed_load = 1'b0;
    logic [7:0] seed_in = 8'h00;
    logic       req = 1'b0;

    logic       valid8, busy8, fixed8;
    logic [5:0] value8;
    logic [7:0] state8;
    logic       valid4, busy4, fixed4;
    logic [5:0] value4;
    logic [7:0] state4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lfsr_random_gen_param dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_seed_load(seed_load),
        .i_seed_in(seed_in), .i_req(req), .o_valid(valid8), .o_value(value8),
        .o_busy(busy8), .o_state_out(state8), .o_seed_fixed(fixed8)
    );

    lfsr_random_gen_param #(.MAX_TRIES(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_seed_load(seed_load),
        .i_seed_in(seed_in), .i_req(req), .o_valid(valid4), .o_value(value4),
        .o_busy(busy4), .o_state_out(state4), .o_seed_fixed(fixed4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int busy_cnt, t8, t4, v8, v4, vcnt8, vcnt4, first_rep, fix_cnt;

        // Reset
        tick();
        tick();
        check("rst_valid", valid8, 0);
        check("rst_value", value8, 0);
        check("rst_busy", busy8, 0);
        check("rst_state", state8, 8'h01);
        check("rst_fixed", fixed8, 0);
        rst = 1'b1;

        // Seed 01, single-cycle draw -> 2
        seed_load = 1'b1; seed_in = 8'h01;
        tick();
        seed_load = 1'b0; req = 1'b1;
        tick();
        req = 1'b0;
        check("t1_valid", valid8, 1);
        check("t1_value", value8, 2);
        check("t1_state", state8, 8'h02);
        check("t1_busy", busy8, 0);
        tick();
        check("t1_valid_drop", valid8, 0);

        // Seed 3F: 63,63,62,60,56,48 rejected, 33 accepted; MAX_TRIES=4 forces 60-40=20
        seed_load = 1'b1; seed_in = 8'h3F;
        tick();
        seed_load = 1'b0;
        check("t2_seed", state8, 8'h3F);
        req = 1'b1;
        tick();
        req = 1'b0;
        busy_cnt = 0; t8 = 0; t4 = 0; v8 = 0; v4 = 0; vcnt8 = 0; vcnt4 = 0;
        for (int i = 1; i <= 12; i++) begin
            if (busy8) busy_cnt++;
            if (valid8) begin vcnt8++; if (t8 == 0) begin t8 = i; v8 = value8; end end
            if (valid4) begin vcnt4++; if (t4 == 0) begin t4 = i; v4 = value4; end end
            tick();
        end
        check("t2_lat8", t8, 7);
        check("t2_val8", v8, 33);
        check("t2_busy8", busy_cnt, 6);
        check("t2_vcnt8", vcnt8, 1);
        check("t2_state8", state8, 8'hE1);
        check("t2_lat4", t4, 4);
        check("t2_val4", v4, 20);
        check("t2_vcnt4", vcnt4, 1);

        // Zero seed substitution and maximal period
        seed_load = 1'b1; seed_in = 8'h00;
        tick();
        seed_load = 1'b0;
        check("t3_state", state8, 8'h01);
        check("t3_fixed", fixed8, 1);
        en = 1'b1;
        first_rep = 0; fix_cnt = 0;
        for (int k = 1; k <= 255; k++) begin
            tick();
            if (fixed8) fix_cnt++;
            if (state8 == 8'h01 && first_rep == 0) first_rep = k;
        end
        en = 1'b0;
        check("t3_period", first_rep, 255);
        check("t3_fix_once", fix_cnt, 0);
        tick();
        check("t3_hold", state8, 8'h01);

        // Reset in the middle of a draw
        seed_load = 1'b1; seed_in = 8'h3F;
        tick();
        seed_load = 1'b0; req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        tick();
        check("t4_busy_pre", busy8, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("t4_state", state8, 8'h01);
        check("t4_busy", busy8, 0);
        check("t4_valid", valid8, 0);
        check("t4_value", value8, 0);
        vcnt8 = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid8 || busy8) vcnt8++;
        end
        check("t4_no_late", vcnt8, 0);

        // seed_load together with req: load wins, no step, no valid
        seed_load = 1'b1; seed_in = 8'h55; req = 1'b1;
        tick();
        seed_load = 1'b0; req = 1'b0;
        check("t5_state", state8, 8'h55);
        check("t5_valid", valid8, 0);
        check("t5_busy", busy8, 0);

        // seed_load mid-DRAW aborts, previous value kept
        seed_load = 1'b1; seed_in = 8'h01;
        tick();
        seed_load = 1'b0; req = 1'b1;
        tick();
        req = 1'b0;
        check("t6_value_pre", value8, 2);
        seed_load = 1'b1; seed_in = 8'h3F;
        tick();
        seed_load = 1'b0; req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        check("t6_busy_pre", busy8, 1);
        seed_load = 1'b1; seed_in = 8'h10;
        tick();
        seed_load = 1'b0;
        check("t6_busy", busy8, 0);
        check("t6_valid", valid8, 0);
        check("t6_value", value8, 2);
        check("t6_state", state8, 8'h10);
        vcnt8 = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid8 || busy8) vcnt8++;
        end
        check("t6_no_late", vcnt8, 0);
        check("t6_hold", state8, 8'h10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
